// File: rtl/data_ram_arbiter.sv
// Two-master arbiter in front of a single-port data RAM. Grants are zero-wait and combinational;
// a burst counter bounds how long one master may hold the RAM while the other is waiting.
module data_ram_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,

    output logic        ram_ce,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             gnt0, gnt1;
    logic             burst_done;
    owner_t           granted;

    assign burst_done = (burst_cnt_q >= MAX_CNT);

    // rst gates the grants directly so ack and ram_ce drop without waiting for a clock edge.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req && !m1_req) begin
                gnt0 = 1'b1;
            end else if (m1_req && !m0_req) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                case (owner_q)
                    OWN_M0: begin
                        gnt0 = !burst_done;
                        gnt1 = burst_done;
                    end
                    OWN_M1: begin
                        gnt1 = !burst_done;
                        gnt0 = burst_done;
                    end
                    default: gnt0 = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        granted     = gnt0 ? OWN_M0 : OWN_M1;
        if (!gnt0 && !gnt1) begin
            owner_d     = OWN_IDLE;
            burst_cnt_d = '0;
        end else if (granted != owner_q) begin
            owner_d     = granted;
            burst_cnt_d = ONE_CNT;
        end else if (burst_cnt_q < MAX_CNT) begin
            burst_cnt_d = burst_cnt_q + ONE_CNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q     <= OWN_IDLE;
            burst_cnt_q <= '0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        ram_ce    = gnt0 | gnt1;
        ram_we    = 1'b0;
        ram_sel   = 4'b0000;
        ram_addr  = 32'h0;
        ram_wdata = 32'h0;
        if (gnt0) begin
            ram_we    = m0_we;
            ram_sel   = m0_sel;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
        end else if (gnt1) begin
            ram_we    = m1_we;
            ram_sel   = m1_sel;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
        end
    end

    assign m0_ack   = gnt0;
    assign m1_ack   = gnt1;
    assign m0_rdata = (gnt0 && !m0_we) ? ram_rdata : 32'h0;
    assign m1_rdata = (gnt1 && !m1_we) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Bench for data_ram_arbiter: behavioural RAM, a table of single-cycle vectors and
// hand-written sequences for reset, saturation, fairness, early release and mid-burst reset.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem [0:63] = '{default: 32'h0};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_ram_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Single-port RAM: combinational read, byte-lane write at the clock edge.
    assign ram_rdata = mem[ram_addr[7:2]];
    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [3:0]  s0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [3:0]  s1;
        logic [31:0] a1, d1;
        logic        e_ack0, e_ack1, e_ce;
        logic [31:0] e_rd0, e_rd1, e_addr;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic r0, logic w0, logic [3:0] s0, logic [31:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [3:0] s1, logic [31:0] a1, logic [31:0] d1,
                                logic ea0, logic ea1, logic ece,
                                logic [31:0] erd0, logic [31:0] erd1, logic [31:0] eaddr);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.s0 = s0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.s1 = s1; v.a1 = a1; v.d1 = d1;
        v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_ce = ece;
        v.e_rd0 = erd0; v.e_rd1 = erd1; v.e_addr = eaddr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [3:0] s0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1, input logic [3:0] s1,
                         input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_sel = s0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_sel = s1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with both masters requesting and m0 trying to write.
        rst = 1'b1;
        drive(1, 1, 4'hF, 32'h30, 32'h12345678, 1, 0, 4'hF, 32'h10, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ce", {31'b0, ram_ce}, 32'd0);
        chk("rst_ack0", {31'b0, m0_ack}, 32'd0);
        chk("rst_ack1", {31'b0, m1_ack}, 32'd0);
        chk("rst_mem", mem[12], 32'h0);
        $display("txn reset: ce=%b ack0=%b ack1=%b", ram_ce, m0_ack, m1_ack);
        rst = 1'b0;
        #1;
        chk("rel_ack0", {31'b0, m0_ack}, 32'd1);
        chk("rel_ack1", {31'b0, m1_ack}, 32'd0);
        $display("txn release: ack0=%b ack1=%b", m0_ack, m1_ack);
        idle();

        // Table of single-cycle vectors, applied in order from an IDLE owner.
        vecs[0] = mk(0,0,4'h0,32'h0, 32'h0,        1,1,4'hF,32'h10,32'hDEADBEEF, 0,1,1, 32'h0, 32'h0,        32'h10);
        vecs[1] = mk(0,0,4'h0,32'h0, 32'h0,        1,0,4'hF,32'h10,32'h0,        0,1,1, 32'h0, 32'hDEADBEEF, 32'h10);
        vecs[2] = mk(1,1,4'hF,32'h20,32'h11223344, 0,0,4'h0,32'h0, 32'h0,        1,0,1, 32'h0, 32'h0,        32'h20);
        vecs[3] = mk(1,1,4'h8,32'h20,32'hAA000000, 0,0,4'h0,32'h0, 32'h0,        1,0,1, 32'h0, 32'h0,        32'h20);
        vecs[4] = mk(1,0,4'hF,32'h20,32'h0,        0,0,4'h0,32'h0, 32'h0,        1,0,1, 32'hAA223344, 32'h0, 32'h20);
        vecs[5] = mk(0,0,4'h0,32'h20,32'h0,        0,0,4'h0,32'h10,32'h0,        0,0,0, 32'h0, 32'h0,        32'h0);
        vecs[6] = mk(1,1,4'h0,32'h10,32'hFFFFFFFF, 0,0,4'h0,32'h0, 32'h0,        1,0,1, 32'h0, 32'h0,        32'h10);
        vecs[7] = mk(0,0,4'h0,32'h0, 32'h0,        1,0,4'hF,32'h10,32'h0,        0,1,1, 32'h0, 32'hDEADBEEF, 32'h10);
        vecs[8] = mk(1,0,4'hF,32'h20,32'h0,        1,0,4'hF,32'h10,32'h0,        0,1,1, 32'h0, 32'hDEADBEEF, 32'h10);
        vecs[9] = mk(0,0,4'h0,32'h0, 32'h0,        0,0,4'h0,32'h0, 32'h0,        0,0,0, 32'h0, 32'h0,        32'h0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].r0, vecs[i].w0, vecs[i].s0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].s1, vecs[i].a1, vecs[i].d1);
            #2;
            chk($sformatf("vec%0d_ack0", i), {31'b0, m0_ack}, {31'b0, vecs[i].e_ack0});
            chk($sformatf("vec%0d_ack1", i), {31'b0, m1_ack}, {31'b0, vecs[i].e_ack1});
            chk($sformatf("vec%0d_ce", i),   {31'b0, ram_ce}, {31'b0, vecs[i].e_ce});
            chk($sformatf("vec%0d_rd0", i),  m0_rdata, vecs[i].e_rd0);
            chk($sformatf("vec%0d_rd1", i),  m1_rdata, vecs[i].e_rd1);
            chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].e_addr);
            $display("txn vec%0d: ack0=%b ack1=%b ce=%b addr=%h rd0=%h rd1=%h",
                     i, m0_ack, m1_ack, ram_ce, ram_addr, m0_rdata, m1_rdata);
            tick();
        end

        // Long solo ownership saturates the counter; a newly arriving m1 wins at once.
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 4'hF, 32'h20, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
            tick();
        end
        drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
        #2;
        chk("sat_ack0", {31'b0, m0_ack}, 32'd0);
        chk("sat_ack1", {31'b0, m1_ack}, 32'd1);
        $display("txn saturate: ack0=%b ack1=%b", m0_ack, m1_ack);
        idle();

        // Both masters requesting continuously: blocks of four, m0 first.
        for (int i = 0; i < 12; i++) begin
            logic w0;
            w0 = (i < 4) || (i >= 8);
            drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
            #2;
            chk($sformatf("fair%0d_ack0", i), {31'b0, m0_ack}, {31'b0, w0});
            chk($sformatf("fair%0d_ack1", i), {31'b0, m1_ack}, {31'b0, ~w0});
            chk($sformatf("fair%0d_rd0", i), m0_rdata, w0 ? 32'hAA223344 : 32'h0);
            chk($sformatf("fair%0d_rd1", i), m1_rdata, w0 ? 32'h0 : 32'hDEADBEEF);
            $display("txn fair%0d: ack0=%b ack1=%b", i, m0_ack, m1_ack);
            tick();
        end
        idle();

        // Early release: m0 holds two cycles, drops; m1 takes over with a fresh count of 1.
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
            #2;
            chk($sformatf("early%0d_ack0", i), {31'b0, m0_ack}, 32'd1);
            tick();
        end
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
        #2;
        chk("early_drop_ack1", {31'b0, m1_ack}, 32'd1);
        $display("txn early_drop: ack0=%b ack1=%b", m0_ack, m1_ack);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 0, 4'hF, 32'h10, 32'h0);
            #2;
            chk($sformatf("early_cont%0d_ack1", i), {31'b0, m1_ack}, (i < 3) ? 32'd1 : 32'd0);
            $display("txn early_cont%0d: ack0=%b ack1=%b", i, m0_ack, m1_ack);
            tick();
        end
        idle();

        // Reset in the middle of an m1 write burst.
        for (int i = 1; i <= 2; i++) begin
            drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'h44, 32'(i));
            tick();
        end
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 4'hF, 32'h44, 32'h99);
        #2;
        chk("mid_ack1_pre", {31'b0, m1_ack}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_ack1_rst", {31'b0, m1_ack}, 32'd0);
        chk("mid_ce_rst", {31'b0, ram_ce}, 32'd0);
        $display("txn mid_reset: ack1=%b ce=%b", m1_ack, ram_ce);
        tick();
        chk("mid_mem", mem[17], 32'h2);
        drive(1, 0, 4'hF, 32'h20, 32'h0, 1, 1, 4'hF, 32'h44, 32'h99);
        rst = 1'b0;
        #1;
        chk("mid_rel_ack0", {31'b0, m0_ack}, 32'd1);
        chk("mid_rel_ack1", {31'b0, m1_ack}, 32'd0);
        $display("txn mid_release: ack0=%b ack1=%b", m0_ack, m1_ack);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Two-master arbiter in front of the single-port data RAM (byte-lane select, combinational read, write committed at posedge clk).
- Master 0 is the CPU MEM-stage load/store port; master 1 is the auxiliary port (debug/DMA loader).
- Arbitration is single-cycle with burst-limited fairness; the losing master sees ack low and must hold its request (stall).
- RAM-side signals connect directly to the data RAM ports.

Parameters:
- MAX_BURST, 4, max consecutive granted cycles for one master while the other master is requesting; legal range 1..15.
- CNT_W, 4, width of the burst counter; must hold MAX_BURST.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- m0_req  input  1  master 0 access request (level, held until ack)
- m0_we  input  1  master 0 write enable (1 = write)
- m0_sel  input  4  master 0 byte-lane select, bit3 = data[31:24]
- m0_addr  input  32  master 0 byte address
- m0_wdata  input  32  master 0 write data
- m0_ack  output  1  master 0 granted this cycle; access completes this cycle
- m0_rdata  output  32  master 0 read data, valid when m0_ack & ~m0_we
- m1_req, m1_we, m1_sel, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*, for master 1
- ram_ce  output  1  RAM chip enable
- ram_we  output  1  RAM write enable
- ram_sel  output  4  RAM byte-lane select
- ram_addr  output  32  RAM address
- ram_wdata  output  32  to RAM data input
- ram_rdata  input  32  from RAM data output (combinational read)

Behaviour:
- State registers: owner (IDLE / M0 / M1) and burst_cnt (CNT_W bits).
- Reset (async, rst=1): owner=IDLE, burst_cnt=0. While rst is high, both grants are forced to 0, so ram_ce=0 and no write commits.
- Grant logic is combinational from the req inputs and registered state; exactly one master or neither is granted:
  - No req: no grant.
  - Only one req: that master is granted, regardless of burst_cnt.
  - Both req, owner=IDLE: M0 is granted (fixed tie-break).
  - Both req, owner=Mx, burst_cnt < MAX_BURST: Mx is granted.
  - Both req, owner=Mx, burst_cnt >= MAX_BURST: the other master is granted.
- State update at posedge clk:
  - No grant: owner=IDLE, burst_cnt=0.
  - Grant to a master other than owner: owner=granted master, burst_cnt=1.
  - Grant to the same owner: burst_cnt increments, saturating at MAX_BURST.
- Fairness bound: with both masters requesting continuously, grants alternate in blocks of exactly MAX_BURST cycles.
- Latency: zero wait when granted. ack, rdata, and the RAM write all occur in the same cycle as req; the write commits at the closing edge.
- RAM mux:
  - Granted: ram_ce=1; ram_we/sel/addr/wdata are the granted master's signals.
  - No grant: ram_ce=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0.
- Read return:
  - mX_rdata = ram_rdata when mX_ack & ~mX_we, else 32'h0.
  - The non-granted master's rdata is 0.
- Write with sel=4'b0000 is passed through unchanged (RAM writes no lanes); ack is still given.
- A master dropping req mid-burst releases ownership that same cycle.
- If the other master is idle, the current owner can exceed MAX_BURST; the counter saturates.
- Reset asserted mid-burst: ack drops immediately (asynchronously), and arbitration restarts from IDLE after release.

Test Plan:
- Reset: rst=1 with m0_req=m1_req=1, m0_we=1 → ram_ce=0, both ack=0, RAM contents unchanged. Release rst → m0_ack=1 next evaluation (IDLE tie-break).
- Single master: m1 writes 32'hDEADBEEF, sel=4'b1111 to addr 32'h10, then reads it back → m1_ack=1 both cycles, m1_rdata=32'hDEADBEEF on the read, m0_ack=0.
- Byte lanes: m0 writes 32'h11223344 sel=1111, then 32'hAA000000 sel=1000 to addr 0x20 → read returns 32'hAA223344.
- Fairness: both req continuously for 12 cycles from IDLE, MAX_BURST=4 → ack pattern M0×4, M1×4, M0×4. Each loser's rdata=0 while not acked.
- Early release: m0 owns with burst_cnt=2, m0 drops req while m1 requests → m1_ack=1 that same cycle, burst_cnt=1 after the edge.
- Mid-burst reset: assert rst asynchronously during an M1 write burst → m1_ack falls without a clock edge. After release with both requesting, M0 is granted first.
